solar_monitor_mc: RTL and testbench

//  Multi-channel successor to the single-panel solar monitor core behind the user project wrapper.
//  - Accepts time-multiplexed panel samples (channel id + data).
//  - Computes a boxcar average per channel and flags low-output and stale panels.
//  - Tracks the strongest panel and raises one-cycle interrupts toward user_irq[2:0].

---
 rtl/solar_monitor_mc.sv | 124 ++++++++++++
 tb/tb_solar_monitor_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/solar_monitor_mc.sv
// rtl/solar_monitor_mc.sv - multi-channel panel averager with low/stale flags, best-channel tracking and irqs
module solar_monitor_mc #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              smp_valid,
  input  logic [CH_W-1:0]   smp_ch,
  input  logic [DATA_W-1:0] smp_data,
  input  logic [DATA_W-1:0] thr_low,
  input  logic [NUM_CH-1:0] fault_clr,
  output logic              avg_valid,
  output logic [CH_W-1:0]   avg_ch,
  output logic [DATA_W-1:0] avg_data,
  output logic [NUM_CH-1:0] fault_o,
  output logic [NUM_CH-1:0] stale_o,
  output logic [CH_W-1:0]   best_ch,
  output logic              best_valid,
  output logic [2:0]        irq
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [ACC_W-1:0]  acc      [NUM_CH];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [DATA_W-1:0] last_avg [NUM_CH];
  logic [TMR_W-1:0]  timer    [NUM_CH];

  logic              in_range, accept, complete;
  logic [ACC_W-1:0]  sel_acc, sum;
  logic [CNT_W-1:0]  sel_cnt;
  logic [DATA_W-1:0] new_avg, best_val, cand;
  logic [CH_W-1:0]   best_idx;
  logic [NUM_CH-1:0] hit, fault_set, stale_set;

  always_comb begin
    sel_acc   = '0;
    sel_cnt   = '0;
    hit       = '0;
    fault_set = '0;
    stale_set = '0;
    best_val  = '0;
    best_idx  = '0;
    cand      = '0;
    in_range  = ({1'b0, smp_ch} < NUM_CH_L);
    accept    = smp_valid && in_range;
    for (int i = 0; i < NUM_CH; i++) begin
      if (smp_ch == CH_W'(i)) begin
        sel_acc = acc[i];
        sel_cnt = cnt[i];
      end
    end
    complete = accept && (sel_cnt == CNT_LAST);
    sum      = sel_acc + ACC_W'(smp_data);
    new_avg  = DATA_W'(sum >> AVG_LOG2);
    // Strict '>' keeps the lowest index on ties; untouched channels read as 0.
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]       = accept && (smp_ch == CH_W'(i));
      fault_set[i] = complete && hit[i] && (new_avg < thr_low);
      stale_set[i] = !hit[i] && (timer[i] == TMR_MAX - TMR_W'(1));
      cand         = (complete && hit[i]) ? new_avg : last_avg[i];
      if (cand > best_val) begin
        best_val = cand;
        best_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]      <= '0;
        cnt[i]      <= '0;
        last_avg[i] <= '0;
        timer[i]    <= '0;
      end
      avg_valid  <= 1'b0;
      avg_ch     <= '0;
      avg_data   <= '0;
      fault_o    <= '0;
      stale_o    <= '0;
      best_ch    <= '0;
      best_valid <= 1'b0;
      irq        <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i]) begin
          timer[i] <= '0;
          if (complete) begin
            acc[i]      <= '0;
            cnt[i]      <= '0;
            last_avg[i] <= new_avg;
          end else begin
            acc[i] <= sum;
            cnt[i] <= sel_cnt + CNT_W'(1);
          end
        end else if (timer[i] != TMR_MAX) begin
          timer[i] <= timer[i] + TMR_W'(1);
        end
      end
      avg_valid <= complete;
      if (complete) begin
        avg_ch     <= smp_ch;
        avg_data   <= new_avg;
        best_ch    <= best_idx;
        best_valid <= 1'b1;
      end
      // Set wins over a same-cycle clear.
      fault_o <= (fault_o & ~fault_clr) | fault_set;
      stale_o <= (stale_o & ~fault_clr) | stale_set;
      irq     <= {smp_valid && !in_range, |(stale_set & ~stale_o), |(fault_set & ~fault_o)};
    end
  end

endmodule

// File: tb/tb_solar_monitor_mc.sv
// tb/tb_solar_monitor_mc.sv - scoreboard bench for solar_monitor_mc (3 channels, timeout 16)
module tb_solar_monitor_mc;
  localparam int NCH = 3;
  localparam int WIN = 4;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       smp_valid = 1'b0;
  logic [1:0] smp_ch = '0;
  logic [7:0] smp_data = '0;
  logic [7:0] thr_low = '0;
  logic [2:0] fault_clr = '0;
  logic       avg_valid;
  logic [1:0] avg_ch;
  logic [7:0] avg_data;
  logic [2:0] fault_o, stale_o;
  logic [1:0] best_ch;
  logic       best_valid;
  logic [2:0] irq;

  solar_monitor_mc #(.NUM_CH(3), .DATA_W(8), .AVG_LOG2(2), .TIMEOUT_CYC(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .smp_valid(smp_valid), .smp_ch(smp_ch),
    .smp_data(smp_data), .thr_low(thr_low), .fault_clr(fault_clr),
    .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_data(avg_data), .fault_o(fault_o),
    .stale_o(stale_o), .best_ch(best_ch), .best_valid(best_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int data; int best; int cyc; } exp_t;
  exp_t exp_q[$];
  int   bad_q[$];
  int   win_q [NCH][$];
  int   last_m [NCH];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      win_q[c].delete();
      last_m[c] = 0;
    end
  endtask

  // Reference: collect WIN samples per channel, average with integer division.
  task automatic apply(bit v, int ch, int d, logic [2:0] clr);
    int s, a, b;
    smp_valid = v;
    smp_ch    = 2'(ch);
    smp_data  = 8'(d);
    fault_clr = clr;
    if (v) begin
      if (ch >= NCH) bad_q.push_back(cyc + 1);
      else begin
        win_q[ch].push_back(d);
        if (win_q[ch].size() == WIN) begin
          s = 0;
          foreach (win_q[ch][k]) s += win_q[ch][k];
          a = s / WIN;
          last_m[ch] = a;
          b = 0;
          for (int j = 1; j < NCH; j++) if (last_m[j] > last_m[b]) b = j;
          exp_q.push_back('{ch, a, b, cyc + 1});
          win_q[ch].delete();
        end
      end
    end
  endtask

  task automatic drive(int ch, int d, logic [2:0] clr = 3'b000);
    @(negedge clk);
    apply(1'b1, ch, d, clr);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      apply(1'b0, 0, 0, 3'b000);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!wb_rst_i) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("avg_missed", 0, 1);
        void'(exp_q.pop_front());
      end
      if (avg_valid) begin
        if (exp_q.size() == 0) check("avg_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("avg_cycle", cyc, e.cyc);
          check("avg_ch", int'(avg_ch), e.ch);
          check("avg_data", int'(avg_data), e.data);
          check("best_ch", int'(best_ch), e.best);
          check("best_valid", int'(best_valid), 1);
        end
      end
      if (bad_q.size() > 0 && bad_q[0] < cyc) begin
        check("irq2_missed", 0, 1);
        void'(bad_q.pop_front());
      end
      if (irq[2]) begin
        if (bad_q.size() == 0) check("irq2_spurious", 1, 0);
        else check("irq2_cycle", cyc, bad_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c0, pulses;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_avg_ch", int'(avg_ch), 0);
    check("rst_avg_data", int'(avg_data), 0);
    check("rst_fault", int'(fault_o), 0);
    check("rst_stale", int'(stale_o), 0);
    check("rst_best_ch", int'(best_ch), 0);
    check("rst_best_valid", int'(best_valid), 0);
    check("rst_irq", int'(irq), 0);

    // Reset in the middle of a ch0 window must discard the partial sum.
    @(negedge clk) wb_rst_i = 1'b0;
    drive(0, 200);
    drive(0, 200);
    @(negedge clk);
    apply(1'b0, 0, 0, 3'b000);
    wb_rst_i = 1'b1;
    model_reset();
    @(negedge clk) wb_rst_i = 1'b0;
    for (int k = 0; k < 4; k++) drive(0, 8);
    idle(1);
    check("midrst_avg", int'(avg_data), 8);

    for (int k = 0; k < 4; k++) drive(2, 10 + k);
    idle(1);
    check("avg2_ch", int'(avg_ch), 2);
    check("avg2_data", int'(avg_data), 11);
    idle(1);
    check("avg2_pulse_end", int'(avg_valid), 0);

    thr_low = 8'd20;
    for (int k = 0; k < 4; k++) drive(1, 19);
    idle(1);
    check("fault_set", int'(fault_o), 3'b010);
    check("irq0_rise", int'(irq[0]), 1);
    idle(1);
    check("irq0_one_cycle", int'(irq[0]), 0);
    @(negedge clk) apply(1'b0, 0, 0, 3'b010);
    idle(1);
    check("fault_cleared", int'(fault_o), 0);
    for (int k = 0; k < 4; k++) drive(1, 20);
    idle(1);
    check("fault_eq_thr", int'(fault_o), 0);
    check("irq0_eq_thr", int'(irq[0]), 0);
    for (int k = 0; k < 4; k++) drive(1, 19);
    idle(1);
    check("fault_reset", int'(fault_o[1]), 1);
    for (int k = 0; k < 3; k++) drive(1, 19);
    drive(1, 19, 3'b010);
    idle(1);
    check("fault_set_wins", int'(fault_o[1]), 1);
    check("irq0_no_rise", int'(irq[0]), 0);
    idle(2);

    // Stale: feed only ch0 from the first cycle after reset.
    thr_low = 8'd0;
    @(negedge clk) wb_rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    wb_rst_i = 1'b0;
    c0 = cyc;
    apply(1'b1, 0, $urandom_range(0, 255), 3'b000);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cyc - c0 == 15) check("stale_before", int'(stale_o), 0);
      if (cyc - c0 == 16) begin
        check("stale_set", int'(stale_o), 3'b110);
        check("irq1_rise", int'(irq[1]), 1);
      end
      if (cyc - c0 == 17) check("irq1_one_cycle", int'(irq[1]), 0);
      if (cyc - c0 == 18) check("stale_cleared", int'(stale_o), 0);
      if (cyc - c0 >= 18 && irq[1]) pulses++;
      apply(1'b1, 0, $urandom_range(0, 255), (cyc - c0 == 17) ? 3'b110 : 3'b000);
    end
    idle(2);
    check("stale_no_reset", int'(stale_o), 0);
    check("irq1_no_repulse", pulses, 0);

    // Ties go to the lowest index.
    @(negedge clk) wb_rst_i = 1'b1;
    model_reset();
    @(negedge clk) wb_rst_i = 1'b0;
    for (int k = 0; k < 4; k++) drive(2, 50);
    idle(1);
    check("best_ch2", int'(best_ch), 2);
    for (int k = 0; k < 4; k++) drive(1, 50);
    idle(1);
    check("best_tie", int'(best_ch), 1);
    for (int k = 0; k < 4; k++) drive(1, 40);
    idle(1);
    check("best_drop", int'(best_ch), 2);

    // Bad id inside a window leaves the accumulator untouched.
    drive(0, 4);
    drive(0, 4);
    drive(3, 255);
    idle(1);
    check("irq2_bad_id", int'(irq[2]), 1);
    drive(0, 4);
    drive(0, 4);
    idle(1);
    check("bad_id_avg", int'(avg_data), 4);

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255), 3'b000);
    end
    idle(3);
    check("avg_queue_drained", exp_q.size(), 0);
    check("irq2_queue_drained", bad_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
